alu_acc_unit: RTL and testbench

ALU_ACC_UNIT -- requirements
Module: alu_acc_unit

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_acc_unit.sv | 132 +++++++++++++
 tb/tb_alu_acc_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator front-end of the external 5-bit ALU:
// op-code encodings, FSM state type and the datapath width default.
package alu_pkg;

    localparam int WIDTH = 5;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_acc_unit.sv
// Command sequencer and accumulator wrapped around an external combinational ALU.
// Optional zero flag on the captured result: define ALU_ACC_ZFLAG_EN.
//
//   state | meaning
//   IDLE  | ready for a command; in_clr clears acc
//   ISSUE | operands on alu_*; result captured at the closing edge
//   HOLD  | out_valid high, waiting for out_ready; in_clr clears acc
module alu_acc_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [1:0]       in_sel,
    input  logic             in_acc,
    input  logic             in_clr,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef ALU_ACC_ZFLAG_EN
    output logic             out_zero,
`endif
    output logic [WIDTH-1:0] acc
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] acc_eff;
`ifdef ALU_ACC_ZFLAG_EN
    logic             zero_q, zero_d;
`endif

    // A clear in the accept cycle must already be visible to the issued operand.
    assign acc_eff = in_clr ? '0 : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            out_data_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
        end
    end

`ifdef ALU_ACC_ZFLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
`ifdef ALU_ACC_ZFLAG_EN
        zero_d     = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_clr) begin
                    acc_d = '0;
                end
                if (in_valid) begin
                    alu_a_d   = in_acc ? acc_eff : in_A;
                    alu_b_d   = in_B;
                    alu_sel_d = in_sel;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                out_data_d = alu_out;
                acc_d      = alu_out;
`ifdef ALU_ACC_ZFLAG_EN
                zero_d     = (alu_out == '0);
`endif
                state_d    = HOLD;
            end
            HOLD: begin
                if (in_clr) begin
                    acc_d = '0;
                end
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign alu_A     = alu_a_q;
    assign alu_B     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign out_data  = out_data_q;
    assign acc       = acc_q;
`ifdef ALU_ACC_ZFLAG_EN
    assign out_zero  = zero_q;
`endif

endmodule

// File: tb/tb_alu_acc_unit.sv
// Directed bench for alu_acc_unit with a behavioural model of the external ALU.
module tb_alu_acc_unit;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_A = '0;
    logic [4:0] in_B = '0;
    logic [1:0] in_sel = '0;
    logic       in_acc = 1'b0;
    logic       in_clr = 1'b0;
    logic [4:0] alu_A, alu_B, alu_out;
    logic [1:0] alu_sel;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [4:0] out_data;
    logic [4:0] acc;
`ifdef ALU_ACC_ZFLAG_EN
    logic       out_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_acc_unit #(.WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_sel(in_sel), .in_acc(in_acc), .in_clr(in_clr),
        .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef ALU_ACC_ZFLAG_EN
        .out_zero(out_zero),
`endif
        .acc(acc)
    );

    always #5 clk = ~clk;

    // External ALU model.
    always_comb begin
        case (alu_sel)
            OP_AND:  alu_out = alu_A & alu_B;
            OP_ADD:  alu_out = alu_A + alu_B;
            OP_OR:   alu_out = alu_A | alu_B;
            default: alu_out = alu_A ^ alu_B;
        endcase
    end

    // Called just after a falling edge; offers one command for the next rising
    // edge and returns just after the following falling edge (state ISSUE).
    task automatic drive_cmd(input logic [4:0] a, input logic [4:0] b,
                             input logic [1:0] sel, input logic use_acc, input logic clr);
        in_valid = 1'b1; in_A = a; in_B = b; in_sel = sel; in_acc = use_acc; in_clr = clr;
        @(negedge clk);
        in_valid = 1'b0; in_clr = 1'b0;
        in_A = 5'($urandom); in_B = 5'($urandom); in_sel = 2'($urandom); in_acc = 1'($urandom);
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (acc !== 5'd0) begin n_fail++; $display("FAIL rst_acc: got %0d want 0", acc); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_data !== 5'd0 || alu_A !== 5'd0 || alu_B !== 5'd0 || alu_sel !== 2'b00) begin
            n_fail++; $display("FAIL rst_regs: got out_data=%0d alu_A=%0d alu_B=%0d alu_sel=%0d want all 0", out_data, alu_A, alu_B, alu_sel);
        end
`ifdef ALU_ACC_ZFLAG_EN
        n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL rst_zero: got %b want 1", out_zero); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add;
        drive_cmd(5'd3, 5'd4, OP_ADD, 1'b0, 1'b0);
        n_checks++; if (alu_A !== 5'd3 || alu_B !== 5'd4 || alu_sel !== OP_ADD) begin
            n_fail++; $display("FAIL add_operands: got A=%0d B=%0d sel=%0d want 3 4 1", alu_A, alu_B, alu_sel);
        end
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL add_issue: got out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 5'd7 || acc !== 5'd7) begin
            n_fail++; $display("FAIL add_result: got out_data=%0d acc=%0d want 7 7", out_data, acc);
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 5'd7) begin
            n_fail++; $display("FAIL add_release: got out_valid=%b in_ready=%b out_data=%0d want 0 1 7", out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_wrap;
        drive_cmd(5'd31, 5'd30, OP_ADD, 1'b1, 1'b0);
        n_checks++; if (alu_A !== 5'd7) begin n_fail++; $display("FAIL wrap_opA: got %0d want 7", alu_A); end
        @(negedge clk);
        n_checks++; if (out_data !== 5'd5 || acc !== 5'd5 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_result: got out_data=%0d acc=%0d valid=%b want 5 5 1", out_data, acc, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive_cmd(5'd12, 5'd10, OP_AND, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_A = 5'd1; in_B = 5'd1; in_sel = OP_ADD;
            n_checks++; if (out_valid !== 1'b1 || out_data !== 5'd8 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: got valid=%b data=%0d in_ready=%b want 1 8 0", k, out_valid, out_data, in_ready);
            end
            n_checks++; if (alu_A !== 5'd12 || alu_sel !== OP_AND) begin
                n_fail++; $display("FAIL bp_alu_hold%0d: got A=%0d sel=%0d want 12 0", k, alu_A, alu_sel);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 5'd8) begin
            n_fail++; $display("FAIL bp_release: got valid=%b in_ready=%b data=%0d want 0 1 8", out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_clr_same_cycle;
        drive_cmd(5'd9, 5'd0, OP_OR, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (acc !== 5'd9) begin n_fail++; $display("FAIL clrsc_setup: got acc=%0d want 9", acc); end
        @(negedge clk);
        drive_cmd(5'd17, 5'd5, OP_XOR, 1'b1, 1'b1);
        n_checks++; if (alu_A !== 5'd0 || acc !== 5'd0) begin
            n_fail++; $display("FAIL clrsc_opA: got alu_A=%0d acc=%0d want 0 0", alu_A, acc);
        end
        @(negedge clk);
        n_checks++; if (out_data !== 5'd5 || acc !== 5'd5) begin
            n_fail++; $display("FAIL clrsc_result: got out_data=%0d acc=%0d want 5 5", out_data, acc);
        end
        @(negedge clk);
    endtask

    task automatic test_clr_states;
        in_clr = 1'b1;
        @(negedge clk);
        in_clr = 1'b0;
        n_checks++; if (acc !== 5'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL clr_idle: got acc=%0d in_ready=%b want 0 1", acc, in_ready);
        end
        out_ready = 1'b0;
        drive_cmd(5'd6, 5'd2, OP_ADD, 1'b0, 1'b0);
        in_clr = 1'b1;
        @(negedge clk);
        in_clr = 1'b0;
        n_checks++; if (acc !== 5'd8 || out_data !== 5'd8) begin
            n_fail++; $display("FAIL clr_issue_ignored: got acc=%0d out_data=%0d want 8 8", acc, out_data);
        end
        in_clr = 1'b1;
        @(negedge clk);
        in_clr = 1'b0;
        n_checks++; if (acc !== 5'd0 || out_data !== 5'd8 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL clr_hold: got acc=%0d out_data=%0d valid=%b want 0 8 1", acc, out_data, out_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_in_issue;
        drive_cmd(5'd9, 5'd9, OP_ADD, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (acc !== 5'd18) begin n_fail++; $display("FAIL rsti_setup: got acc=%0d want 18", acc); end
        drive_cmd(5'd1, 5'd2, OP_ADD, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (acc !== 5'd0 || in_ready !== 1'b1 || alu_A !== 5'd0) begin
            n_fail++; $display("FAIL rsti_async: got acc=%0d in_ready=%b alu_A=%0d want 0 1 0", acc, in_ready, alu_A);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rsti_no_valid%0d: got %b want 0", k, out_valid); end
        end
        rst = 1'b0;
        drive_cmd(5'd1, 5'd1, OP_ADD, 1'b0, 1'b0);
        n_checks++; if (alu_A !== 5'd1 || alu_B !== 5'd1) begin
            n_fail++; $display("FAIL rsti_first_accept: got A=%0d B=%0d want 1 1", alu_A, alu_B);
        end
        begin
            int waited = 0;
            while (out_valid !== 1'b1 && waited < 4) begin
                @(negedge clk);
                waited++;
            end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rsti_timeout: out_valid=%b after %0d cycles want 1", out_valid, waited); end
        end
        n_checks++; if (out_data !== 5'd2 || acc !== 5'd2) begin
            n_fail++; $display("FAIL rsti_next_add: got out_data=%0d acc=%0d want 2 2", out_data, acc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_hold;
        out_ready = 1'b0;
        drive_cmd(5'd4, 5'd4, OP_ADD, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || acc !== 5'd0 || out_data !== 5'd0 || in_ready !== 1'b1 || alu_B !== 5'd0 || alu_sel !== 2'b00) begin
            n_fail++; $display("FAIL rsth_async: got valid=%b acc=%0d data=%0d in_ready=%b alu_B=%0d sel=%0d want 0 0 0 1 0 0",
                               out_valid, acc, out_data, in_ready, alu_B, alu_sel);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        drive_cmd(5'd21, 5'd10, OP_XOR, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (out_data !== 5'd31 || acc !== 5'd31) begin
            n_fail++; $display("FAIL b2b_xor: got out_data=%0d acc=%0d want 31 31", out_data, acc);
        end
        @(negedge clk);
        drive_cmd(5'd0, 5'd1, OP_ADD, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (out_data !== 5'd0 || acc !== 5'd0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_wrap0: got out_data=%0d acc=%0d valid=%b want 0 0 1", out_data, acc, out_valid);
        end
`ifdef ALU_ACC_ZFLAG_EN
        n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL b2b_zero_set: got %b want 1", out_zero); end
`endif
        @(negedge clk);
        drive_cmd(5'd16, 5'd3, OP_OR, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (out_data !== 5'd19 || acc !== 5'd19) begin
            n_fail++; $display("FAIL b2b_or: got out_data=%0d acc=%0d want 19 19", out_data, acc);
        end
`ifdef ALU_ACC_ZFLAG_EN
        n_checks++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL b2b_zero_clr: got %b want 0", out_zero); end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_add;
        test_wrap;
        test_backpressure;
        test_clr_same_cycle;
        test_clr_states;
        test_reset_in_issue;
        test_reset_in_hold;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
